// File: rtl/iic_target_regs.sv
// I2C target that turns bus write/read transactions into a single-cycle
// register-bus interface. The protocol is a 7-bit device address, a 16-bit
// register pointer sent MSB first, and 8-bit data. The pointer auto-increments,
// and a repeated START gives a random read. SDA is open-drain and SCL is input only.
//
// Handshake: there is no valid/ready pair on the register side. reg_wr is a
// one-cycle strobe with reg_addr/reg_wdata valid in that same cycle. reg_rd is a
// one-cycle strobe, and reg_rdata is captured in the cycle after the strobe.
// There is no back-pressure: the bus is never stretched.
module iic_target_regs #(
    parameter logic [6:0] DEV_ADDR   = 7'h2B,
    parameter int         FILTER_LEN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic        reg_wr,
    output logic [7:0]  reg_wdata,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_DEV     = 4'd1,
        S_ACK_DEV = 4'd2,
        S_AH      = 4'd3,
        S_ACK_AH  = 4'd4,
        S_AL      = 4'd5,
        S_ACK_AL  = 4'd6,
        S_WDATA   = 4'd7,
        S_ACK_W   = 4'd8,
        S_RDATA   = 4'd9,
        S_MACK    = 4'd10,
        S_IGNORE  = 4'd11
    } state_t;

    state_t state, state_nxt;

    logic [1:0] scl_sync, sda_sync;
    logic [2:0] scl_cnt, sda_cnt;
    logic       scl_f, sda_f, scl_d, sda_d;

    logic [2:0] bit_cnt;      // bit index in a byte; ACK/MACK phase (0/1) otherwise
    logic [6:0] shreg;        // receive shift register / remaining transmit bits
    logic [7:0] addr_hi;
    logic       rw;
    logic       rd_d;         // reg_rd delayed: reg_rdata is valid this cycle

    logic       oe_nxt, wr_nxt, rd_nxt, busy_nxt;

    // Two-flop synchronisers; the idle bus level is high
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

    // Run filters: a filtered level changes only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= 3'd0;
            sda_cnt <= 3'd0;
            scl_d   <= 1'b1;
            sda_d   <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= 3'd0;
            end else if (scl_cnt == 3'(FILTER_LEN - 1)) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= 3'd0;
            end else begin
                scl_cnt <= scl_cnt + 3'd1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= 3'd0;
            end else if (sda_cnt == 3'(FILTER_LEN - 1)) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= 3'd0;
            end else begin
                sda_cnt <= sda_cnt + 3'd1;
            end
        end
    end

    // Bus events. START/STOP require SCL to be steady high, so an SCL edge in the
    // same cycle as an SDA edge is treated as an SCL edge only.
    logic scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;

    logic       rx_state, ack_state, bit_rx, byte_done, ack_begin, ack_end;
    logic       mack_ack, mack_nack, mack_end, dev_match;
    logic [7:0] rx_byte;

    assign rx_state  = (state == S_DEV) || (state == S_AH) || (state == S_AL) || (state == S_WDATA);
    assign ack_state = (state == S_ACK_DEV) || (state == S_ACK_AH) || (state == S_ACK_AL) || (state == S_ACK_W);
    assign bit_rx    = rx_state & scl_rise;
    assign byte_done = bit_rx & (bit_cnt == 3'd7);
    assign rx_byte   = {shreg, sda_f};
    assign dev_match = (rx_byte[7:1] == DEV_ADDR);
    // ACK bit window: drive from the fall after bit 8 until the following fall
    assign ack_begin = ack_state & scl_fall & (bit_cnt == 3'd0);
    assign ack_end   = ack_state & scl_fall & (bit_cnt == 3'd1);
    assign mack_ack  = (state == S_MACK) & scl_rise & (bit_cnt == 3'd0) & ~sda_f;
    assign mack_nack = (state == S_MACK) & scl_rise & (bit_cnt == 3'd0) & sda_f;
    assign mack_end  = (state == S_MACK) & scl_fall & (bit_cnt == 3'd1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; START and STOP override every state
    always_comb begin
        state_nxt = state;
        if (start_ev) begin
            state_nxt = S_DEV;
        end else if (stop_ev) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_DEV:     if (byte_done) state_nxt = dev_match ? S_ACK_DEV : S_IGNORE;
                S_ACK_DEV: if (ack_end)   state_nxt = rw ? S_RDATA : S_AH;
                S_AH:      if (byte_done) state_nxt = S_ACK_AH;
                S_ACK_AH:  if (ack_end)   state_nxt = S_AL;
                S_AL:      if (byte_done) state_nxt = S_ACK_AL;
                S_ACK_AL:  if (ack_end)   state_nxt = S_WDATA;
                S_WDATA:   if (byte_done) state_nxt = S_ACK_W;
                S_ACK_W:   if (ack_end)   state_nxt = S_WDATA;
                S_RDATA:   if (!rd_d && scl_fall && bit_cnt == 3'd7) state_nxt = S_MACK;
                S_MACK: begin
                    if (mack_nack)     state_nxt = S_IGNORE;
                    else if (mack_end) state_nxt = S_RDATA;
                end
                default:   state_nxt = state;
            endcase
        end
    end

    // Output logic: next values of the registered pad and strobe outputs
    always_comb begin
        oe_nxt   = sda_oe;
        wr_nxt   = 1'b0;
        rd_nxt   = 1'b0;
        busy_nxt = busy;
        if (start_ev || stop_ev) begin
            oe_nxt   = 1'b0;
            busy_nxt = 1'b0;
        end else begin
            if (state == S_DEV && byte_done && dev_match) busy_nxt = 1'b1;
            if (ack_begin) oe_nxt = 1'b1;
            if (ack_end) begin
                oe_nxt = 1'b0;
                if (state == S_ACK_DEV && rw) rd_nxt = 1'b1;
            end
            if (state == S_WDATA && byte_done) wr_nxt = 1'b1;
            if (state == S_RDATA) begin
                if (rd_d)          oe_nxt = ~reg_rdata[7];
                else if (scl_fall) oe_nxt = (bit_cnt == 3'd7) ? 1'b0 : ~shreg[6];
            end
            if (mack_nack) busy_nxt = 1'b0;
            if (mack_end)  rd_nxt   = 1'b1;
            if (state == S_IDLE || state == S_IGNORE) oe_nxt = 1'b0;
        end
    end

    // Registered outputs; reset releases SDA on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sda_oe <= 1'b0;
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            busy   <= 1'b0;
        end else begin
            sda_oe <= oe_nxt;
            reg_wr <= wr_nxt;
            reg_rd <= rd_nxt;
            busy   <= busy_nxt;
        end
    end

    // Datapath: bit counter, shift register, pointer and write data
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            addr_hi   <= 8'h00;
            rw        <= 1'b0;
            reg_addr  <= 16'h0000;
            reg_wdata <= 8'h00;
            rd_d      <= 1'b0;
        end else begin
            rd_d <= reg_rd;
            if (start_ev || stop_ev) begin
                bit_cnt <= 3'd0;
            end else if (bit_rx) begin
                shreg   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    case (state)
                        S_DEV:   rw        <= rx_byte[0];
                        S_AH:    addr_hi   <= rx_byte;
                        S_AL:    reg_addr  <= {addr_hi, rx_byte};
                        S_WDATA: reg_wdata <= rx_byte;
                        default: ;
                    endcase
                end
            end else if (ack_begin) begin
                bit_cnt <= 3'd1;
            end else if (ack_end) begin
                bit_cnt <= 3'd0;
                if (state == S_ACK_W) reg_addr <= reg_addr + 16'd1;
            end else if (state == S_RDATA) begin
                if (rd_d) begin
                    shreg   <= reg_rdata[6:0];
                    bit_cnt <= 3'd0;
                end else if (scl_fall) begin
                    shreg   <= {shreg[5:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else if (mack_ack) begin
                bit_cnt <= 3'd1;
            end else if (mack_end) begin
                bit_cnt  <= 3'd0;
                reg_addr <= reg_addr + 16'd1;
            end
        end
    end

    assign state_dbg = state;

endmodule
